// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the centisecond stopwatch control slice.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        RECALL
    } state_t;

    typedef struct packed {
        logic [5:0] sec;
        logic [6:0] cs;
    } lap_t;

    localparam int unsigned MAX_SEC = 59;
    localparam int unsigned MAX_CS  = 99;

endpackage

// File: rtl/key_debounce.sv
// Active-low push-button conditioner: 2-flop synchronizer, stability counter,
// single-cycle pulse on a debounced press (1->0). Release produces no pulse.
module key_debounce #(
    parameter int unsigned DEB_CYCLES = 500_000
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    localparam int unsigned CW = $clog2(DEB_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            press <= 1'b0;
            // Any sample agreeing with the accepted level restarts the stability window.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYCLES - 1)) begin
                cnt   <= '0;
                level <= sync2;
                press <= ~sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing: button debounce, run/pause/recall FSM, 100 Hz count
// enable, circular lap buffer and display source selection.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned TICK_HZ    = 100,
    parameter int unsigned DEB_CYCLES = 500_000,
    parameter int unsigned LAP_DEPTH  = 3
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic [2:0]           key_n,
    input  logic [LAP_DEPTH-1:0] sw_recall,
    input  logic [5:0]           cur_sec,
    input  logic [6:0]           cur_cs,
    output logic                 cnt_en,
    output logic                 cnt_clr,
    output logic [5:0]           disp_sec,
    output logic [6:0]           disp_cs,
    output logic                 run_led,
    output logic                 recall_led,
    output logic [LAP_DEPTH-1:0] lap_valid
);

    localparam int unsigned    DIV      = CLK_HZ / TICK_HZ;
    localparam int unsigned    PW       = $clog2(DIV);
    localparam int unsigned    AW       = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
    localparam logic [PW-1:0]  PRE_TERM = PW'(DIV - 1);
    localparam logic [AW-1:0]  LAST     = AW'(LAP_DEPTH - 1);

    state_t        state;
    logic [PW-1:0] presc;
    logic [AW-1:0] wr_ptr;
    lap_t          laps [LAP_DEPTH];
    logic          p_ss;
    logic          p_clr;
    logic          p_lap;
    logic          lap_take;
    logic          found;
    logic [AW-1:0] sel;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ss (
        .CLOCK_50(CLOCK_50), .reset(reset), .key_n(key_n[0]), .press(p_ss)
    );
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
        .CLOCK_50(CLOCK_50), .reset(reset), .key_n(key_n[1]), .press(p_clr)
    );
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_lap (
        .CLOCK_50(CLOCK_50), .reset(reset), .key_n(key_n[2]), .press(p_lap)
    );

    assign lap_take   = (state == RUN) && p_lap && !p_ss && !p_clr;
    assign run_led    = (state == RUN);
    assign recall_led = (state == RECALL);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state     <= IDLE;
            presc     <= '0;
            wr_ptr    <= '0;
            lap_valid <= '0;
            cnt_en    <= 1'b0;
            cnt_clr   <= 1'b0;
        end else begin
            cnt_en  <= 1'b0;
            cnt_clr <= p_clr;
            if (p_clr) begin
                state     <= IDLE;
                presc     <= '0;
                wr_ptr    <= '0;
                lap_valid <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (p_ss) begin
                            state <= RUN;
                            presc <= '0;
                        end
                    end
                    RUN: begin
                        // A pause landing on the terminal count suppresses that tick.
                        if (p_ss) begin
                            state <= PAUSE;
                        end else begin
                            if (presc == PRE_TERM) begin
                                presc  <= '0;
                                cnt_en <= 1'b1;
                            end else begin
                                presc <= presc + 1'b1;
                            end
                            if (lap_take) begin
                                lap_valid[wr_ptr] <= 1'b1;
                                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
                            end
                        end
                    end
                    PAUSE: begin
                        if (p_ss) begin
                            state <= RUN;
                        end else if (sw_recall != '0) begin
                            state <= RECALL;
                        end
                    end
                    RECALL: begin
                        if (sw_recall == '0) begin
                            state <= PAUSE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (lap_take) begin
            laps[wr_ptr] <= '{sec: cur_sec, cs: cur_cs};
        end
    end

    always_comb begin
        disp_sec = cur_sec;
        disp_cs  = cur_cs;
        found    = 1'b0;
        sel      = '0;
        for (int unsigned i = 0; i < LAP_DEPTH; i++) begin
            if (!found && sw_recall[AW'(i)]) begin
                found = 1'b1;
                sel   = AW'(i);
            end
        end
        if (state == RECALL) begin
            if (found && lap_valid[sel]) begin
                disp_sec = laps[sel].sec;
                disp_cs  = laps[sel].cs;
            end else begin
                disp_sec = '0;
                disp_cs  = '0;
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed and random button/recall activity against
// a run-length / cycle-count reference model, checked every cycle.
module tb_stopwatch_ctrl;
    import stopwatch_pkg::*;

    localparam int unsigned DEB    = 4;
    localparam int          PERIOD = 1000 / 100;

    logic       clk       = 1'b0;
    logic       reset     = 1'b1;
    logic [2:0] key_n     = 3'b111;
    logic [2:0] sw_recall = 3'b000;
    logic [5:0] cur_sec   = '0;
    logic [6:0] cur_cs    = '0;
    logic       cnt_en;
    logic       cnt_clr;
    logic [5:0] disp_sec;
    logic [6:0] disp_cs;
    logic       run_led;
    logic       recall_led;
    logic [2:0] lap_valid;

    always #5 clk = ~clk;

    stopwatch_ctrl #(
        .CLK_HZ(1000), .TICK_HZ(100), .DEB_CYCLES(DEB), .LAP_DEPTH(3)
    ) dut (
        .CLOCK_50(clk), .reset(reset), .key_n(key_n), .sw_recall(sw_recall),
        .cur_sec(cur_sec), .cur_cs(cur_cs), .cnt_en(cnt_en), .cnt_clr(cnt_clr),
        .disp_sec(disp_sec), .disp_cs(disp_cs), .run_led(run_led),
        .recall_led(recall_led), .lap_valid(lap_valid)
    );

    typedef enum {M_IDLE, M_RUN, M_PAUSE, M_RECALL} mode_t;

    int          n_pass   = 0;
    int          n_checks = 0;
    mode_t       mode     = M_IDLE;
    int          run_cycles;
    bit          exp_en;
    bit          exp_clr;
    bit   [2:0]  exp_valid;
    int          next_slot;
    logic [12:0] lap_mem [3];
    int          low_run [3];
    int          high_run [3];
    bit          armed [3];
    bit          pipe [3][3];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
            $error("%s", tag);
        end
    endtask

    // Press is acted on by the FSM three edges after the DEB-th consecutive low raw sample.
    task automatic model_edge();
        bit due [3];
        if (reset) begin
            mode = M_IDLE; run_cycles = 0; exp_en = 0; exp_clr = 0;
            exp_valid = '0; next_slot = 0;
            for (int k = 0; k < 3; k++) begin
                low_run[k] = 0; high_run[k] = 0; armed[k] = 1;
                for (int j = 0; j < 3; j++) pipe[k][j] = 0;
            end
            return;
        end
        for (int k = 0; k < 3; k++) begin
            due[k]     = pipe[k][2];
            pipe[k][2] = pipe[k][1];
            pipe[k][1] = pipe[k][0];
            pipe[k][0] = 0;
            if (key_n[k] == 1'b0) begin
                low_run[k]++; high_run[k] = 0;
                if (armed[k] && low_run[k] == DEB) begin
                    pipe[k][0] = 1; armed[k] = 0;
                end
            end else begin
                high_run[k]++; low_run[k] = 0;
                if (!armed[k] && high_run[k] == DEB) armed[k] = 1;
            end
        end
        exp_en  = 0;
        exp_clr = due[1];
        if (due[1]) begin
            mode = M_IDLE; run_cycles = 0; exp_valid = '0; next_slot = 0;
        end else begin
            case (mode)
                M_IDLE: if (due[0]) begin mode = M_RUN; run_cycles = 0; end
                M_RUN: begin
                    if (due[0]) mode = M_PAUSE;
                    else begin
                        if (due[2]) begin
                            lap_mem[next_slot]   = {cur_sec, cur_cs};
                            exp_valid[next_slot] = 1'b1;
                            next_slot            = (next_slot + 1) % 3;
                        end
                        run_cycles++;
                        if (run_cycles % PERIOD == 0) exp_en = 1;
                    end
                end
                M_PAUSE: begin
                    if (due[0]) mode = M_RUN;
                    else if (sw_recall != 3'b000) mode = M_RECALL;
                end
                M_RECALL: if (sw_recall == 3'b000) mode = M_PAUSE;
            endcase
        end
    endtask

    task automatic check_outputs();
        logic [5:0] es;
        logic [6:0] ec;
        logic [2:0] low;
        int         idx;
        es = cur_sec;
        ec = cur_cs;
        if (mode == M_RECALL) begin
            low = sw_recall & (~sw_recall + 3'd1);
            es  = '0;
            ec  = '0;
            if (low != 3'b000) begin
                idx = (low == 3'b001) ? 0 : (low == 3'b010) ? 1 : 2;
                if (exp_valid[idx]) {es, ec} = lap_mem[idx];
            end
        end
        check("cnt_en",     16'(cnt_en),     16'(exp_en));
        check("cnt_clr",    16'(cnt_clr),    16'(exp_clr));
        check("run_led",    16'(run_led),    16'(mode == M_RUN));
        check("recall_led", 16'(recall_led), 16'(mode == M_RECALL));
        check("lap_valid",  16'(lap_valid),  16'(exp_valid));
        check("disp_sec",   16'(disp_sec),   16'(es));
        check("disp_cs",    16'(disp_cs),    16'(ec));
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            #1;
            check_outputs();
            cur_sec = 6'($urandom_range(MAX_SEC));
            cur_cs  = 7'($urandom_range(MAX_CS));
        end
    endtask

    task automatic hold(input int k, input int n);
        key_n[k] = 1'b0;
        step(n);
        key_n[k] = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        step(2);

        hold(0, 20);
        step(35);
        hold(0, DEB - 1);
        step(10);
        hold(2, DEB - 1);
        step(10);

        repeat (4) begin
            hold(2, DEB + 1);
            step(DEB + 4);
        end

        hold(0, DEB + 1);
        step(DEB + 4);
        sw_recall = 3'b110;
        step(5);
        hold(0, DEB + 1);
        step(8);
        hold(2, DEB + 1);
        step(8);
        sw_recall = 3'b001;
        step(3);
        sw_recall = 3'b100;
        step(3);
        sw_recall = 3'b000;
        step(5);

        hold(0, DEB + 1);
        for (int i = 0; i < 2 * PERIOD && ((run_cycles + DEB + 2) % PERIOD) != PERIOD - 3; i++)
            step(1);
        hold(0, DEB + 1);
        step(DEB + 9);
        hold(0, DEB + 1);
        step(25);

        repeat (60) begin
            case ($urandom_range(5))
                0, 1: hold(0, DEB + $urandom_range(3));
                2:    hold(2, DEB + $urandom_range(3));
                3:    hold($urandom_range(2), $urandom_range(1, DEB - 1));
                4:    sw_recall = 3'($urandom_range(7));
                default: if ($urandom_range(3) == 0) hold(1, DEB + 1);
            endcase
            step($urandom_range(14));
        end

        sw_recall = 3'b000;
        hold(1, DEB + 1);
        step(DEB + 4);
        hold(0, DEB + 1);
        step(25);
        key_n = 3'b100;
        step(DEB + 1);
        key_n = 3'b111;
        step(DEB + 6);

        hold(0, DEB + 1);
        step(12);
        hold(2, DEB + 1);
        step(DEB + 6);
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
